// File: rtl/fifo_push_arb_if.sv
// Push-side bundle between R requesters, the arbiter and the FIFO write port.
// The master modport is the environment (requesters + FIFO flag source);
// the slave modport is the arbiter that answers with ack/push/push_data.
interface fifo_push_arb_if #(
  parameter int W = 32,
  parameter int R = 4
);
  logic [R-1:0]   req;
  logic [R*W-1:0] req_data;
  logic [R-1:0]   req_last;
  logic [R-1:0]   ack;
  logic           fifo_full;
  logic           push;
  logic [W-1:0]   push_data;

  modport master (
    output req, req_data, req_last, fifo_full,
    input  ack, push, push_data
  );

  modport slave (
    input  req, req_data, req_last, fifo_full,
    output ack, push, push_data
  );
endinterface

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing one FIFO push port between R requesters.
// A grant lasts for a burst that ends on a pushed beat carrying req_last or
// on the MAX_BURST-th pushed beat; fifo_full stalls the burst without loss.
module fifo_push_arb #(
  parameter int W         = 32,
  parameter int R         = 4,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  fifo_push_arb_if.slave   bus,
  output logic [R-1:0]     grant_r,
  output logic             busy_r
);

  localparam int PTR_W = (R > 1) ? $clog2(R) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_reg, state_next;
  logic [R-1:0]       grant_reg, grant_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

  logic [W-1:0]       data_arr [R];
  logic [PTR_W-1:0]   g_idx;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic               burst_end;

  // Unpack the flat requester data bus into one word per requester.
  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[gi*W +: W];
    end
  endgenerate

  // Encode the one-hot grant into the index of the granted requester.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < R; i++) begin
      if (grant_reg[i]) g_idx = PTR_W'(i);
    end
  end

  // Pick the first active request starting at rr_ptr and wrapping modulo R.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = rr_ptr_reg;
    for (int k = 0; k < R; k++) begin
      idx = (int'(rr_ptr_reg) + k) % R;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Next-state and push/ack decode; rst suppresses any push in its own cycle.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    bus.push      = 1'b0;
    bus.ack       = '0;
    bus.push_data = '0;
    burst_end     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Arbitration ignores fifo_full; the stall is handled beat by beat.
        if (win_found) begin
          grant_next    = R'(1) << win_idx;
          beat_cnt_next = '0;
          state_next    = BURST;
        end
      end
      BURST: begin
        if (!rst && bus.req[g_idx] && !bus.fifo_full) begin
          bus.push       = 1'b1;
          bus.ack[g_idx] = 1'b1;
          bus.push_data  = data_arr[g_idx];
          beat_cnt_next  = beat_cnt_reg + CNT_W'(1);
          // This beat is the last one if flagged, or if it is beat MAX_BURST.
          burst_end = bus.req_last[g_idx] ||
                      (beat_cnt_reg == CNT_W'(MAX_BURST - 1));
          if (burst_end) begin
            state_next  = IDLE;
            grant_next  = '0;
            rr_ptr_next = PTR_W'((int'(g_idx) + 1) % R);
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State register with synchronous reset that abandons any open burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  assign grant_r = grant_reg;
  // busy is forced low while rst is held so the reset cycle already reads idle.
  assign busy_r  = (state_reg == BURST) && !rst;

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb: directed scenarios followed by a
// randomized run, every cycle compared against a burst-level reference model.
module tb_fifo_push_arb;
  localparam int W  = 32;
  localparam int R  = 4;
  localparam int MB = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [R-1:0] grant_r;
  logic         busy_r;

  always #5 clk = ~clk;

  fifo_push_arb_if #(.W(W), .R(R)) bus ();

  fifo_push_arb #(.W(W), .R(R), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .grant_r (grant_r),
    .busy_r  (busy_r)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-requester beat source: bit W is the last flag, bits W-1:0 the data.
  logic [W:0] q [R][$];
  bit         en [R];
  logic       full_in;

  // Reference model: owner of the current burst (-1 = none), priority index,
  // and number of beats already pushed in this burst.
  int m_owner, m_ptr, m_beats;

  int         log_who  [$];
  int         log_cyc  [$];
  logic [W-1:0] log_data [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    logic [R-1:0]   r, l;
    logic [R*W-1:0] d;
    r = '0; l = '0; d = '0;
    for (int i = 0; i < R; i++) begin
      if (en[i] && q[i].size() > 0) begin
        r[i]       = 1'b1;
        d[i*W +: W] = q[i][0][W-1:0];
        l[i]       = q[i][0][W];
      end
    end
    bus.req       = r;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.fifo_full = full_in;
  endtask

  // One clock: drive, check outputs mid-cycle against the model, advance.
  task automatic cycle();
    logic         e_push, e_busy;
    logic [R-1:0] e_ack, e_grant;
    logic [W-1:0] e_data;
    int n_owner, n_ptr, n_beats, o;
    drive();
    @(negedge clk);
    e_push  = 1'b0;
    e_ack   = '0;
    e_data  = '0;
    e_grant = (m_owner >= 0) ? (R'(1) << m_owner) : '0;
    e_busy  = (m_owner >= 0) && !rst;
    n_owner = m_owner; n_ptr = m_ptr; n_beats = m_beats;
    o = m_owner;
    if (rst) begin
      n_owner = -1; n_ptr = 0; n_beats = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < R; k++) begin
        if (n_owner < 0 && bus.req[(m_ptr + k) % R]) begin
          n_owner = (m_ptr + k) % R;
          n_beats = 0;
        end
      end
    end else if (bus.req[o] && !full_in) begin
      e_push   = 1'b1;
      e_ack[o] = 1'b1;
      e_data   = bus.req_data[o*W +: W];
      n_beats  = m_beats + 1;
      if (bus.req_last[o] || n_beats == MB) begin
        n_owner = -1;
        n_ptr   = (o + 1) % R;
      end
    end
    check("push", 64'(bus.push), 64'(e_push));
    check("ack", 64'(bus.ack), 64'(e_ack));
    check("push_data", 64'(bus.push_data), 64'(e_data));
    check("grant_r", 64'(grant_r), 64'(e_grant));
    check("busy_r", 64'(busy_r), 64'(e_busy));
    if (e_push) begin
      log_who.push_back(o);
      log_cyc.push_back(cyc);
      log_data.push_back(bus.push_data);
    end
    @(posedge clk);
    #1;
    if (e_push) void'(q[o].pop_front());
    m_owner = n_owner; m_ptr = n_ptr; m_beats = n_beats;
    cyc++;
  endtask

  function automatic bit pending();
    for (int i = 0; i < R; i++)
      if (en[i] && q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while ((pending() || m_owner >= 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    check(tag, 64'(n < max_cyc), 64'(1));
  endtask

  task automatic new_section();
    for (int i = 0; i < R; i++) begin
      q[i].delete();
      en[i] = 1'b1;
    end
    full_in = 1'b0;
    log_who.delete(); log_cyc.delete(); log_data.delete();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic load(input int who, input int n, input logic [W-1:0] base, input bit with_last);
    for (int k = 0; k < n; k++)
      q[who].push_back({(with_last && k == n - 1), base + W'(k)});
  endtask

  initial begin
    int t0, len;
    // Unchecked power-up reset: registers are unknown before the first edge.
    rst = 1'b1;
    full_in = 1'b0;
    for (int i = 0; i < R; i++) en[i] = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    m_owner = -1; m_ptr = 0; m_beats = 0;

    // Reset state held for a few checked cycles.
    new_section();
    repeat (2) cycle();
    check("reset_grant", 64'(grant_r), 64'(0));

    // Single 3-beat burst on requester 2.
    new_section();
    load(2, 3, 32'hA0, 1'b1);
    t0 = cyc;
    run_until_idle(20, "single_timeout");
    check("single_count", 64'(log_who.size()), 64'(3));
    if (log_who.size() == 3) begin
      for (int k = 0; k < 3; k++) check("single_data", 64'(log_data[k]), 64'(32'hA0 + k));
      check("single_first", 64'(log_cyc[0] - t0), 64'(1));
      check("single_lastc", 64'(log_cyc[2] - t0), 64'(3));
    end

    // Round-robin fairness with 1-beat bursts on all requesters.
    new_section();
    for (int i = 0; i < R; i++) begin
      load(i, 1, 32'h10 * i, 1'b1);
      load(i, 1, 32'h10 * i + 1, 1'b1);
    end
    run_until_idle(60, "rr_timeout");
    check("rr_count", 64'(log_who.size()), 64'(8));
    if (log_who.size() == 8) begin
      for (int k = 0; k < 8; k++) check("rr_order", 64'(log_who[k]), 64'(k % R));
      for (int k = 1; k < 8; k++) check("rr_spacing", 64'(log_cyc[k] - log_cyc[k-1]), 64'(2));
    end

    // Forced release: 20 beats without last on requester 1.
    new_section();
    load(1, 20, 32'h100, 1'b0);
    repeat (30) cycle();
    check("force_count", 64'(log_who.size()), 64'(20));
    if (log_who.size() == 20) begin
      for (int k = 0; k < 20; k++) check("force_data", 64'(log_data[k]), 64'(32'h100 + k));
      check("force_gap1", 64'(log_cyc[8] - log_cyc[7]), 64'(2));
      check("force_gap2", 64'(log_cyc[16] - log_cyc[15]), 64'(2));
      check("force_span", 64'(log_cyc[19] - log_cyc[0]), 64'(21));
    end

    // Full stall during beat 2 of a 4-beat burst.
    new_section();
    load(0, 4, 32'h200, 1'b1);
    cycle();
    cycle();
    full_in = 1'b1;
    repeat (3) cycle();
    full_in = 1'b0;
    run_until_idle(20, "full_timeout");
    check("full_count", 64'(log_who.size()), 64'(4));
    if (log_who.size() == 4) begin
      check("full_resume", 64'(log_cyc[1] - log_cyc[0]), 64'(4));
      check("full_beat2", 64'(log_data[1]), 64'(32'h201));
    end

    // Requester 0 drops req mid-burst while requester 3 waits.
    new_section();
    load(0, 4, 32'h300, 1'b1);
    load(3, 2, 32'h330, 1'b1);
    cycle();
    cycle();
    en[0] = 1'b0;
    repeat (2) cycle();
    en[0] = 1'b1;
    run_until_idle(30, "gap_timeout");
    check("gap_count", 64'(log_who.size()), 64'(6));
    if (log_who.size() == 6)
      for (int k = 0; k < 6; k++) check("gap_order", 64'(log_who[k]), 64'((k < 4) ? 0 : 3));

    // Reset during beat 2 of a burst on requester 3.
    new_section();
    load(3, 4, 32'h400, 1'b1);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    load(0, 1, 32'h440, 1'b1);
    run_until_idle(30, "rstmid_timeout");
    check("rstmid_count", 64'(log_who.size()), 64'(5));
    if (log_who.size() == 5) begin
      check("rstmid_next", 64'(log_who[1]), 64'(0));
      check("rstmid_beat2", 64'(log_data[2]), 64'(32'h401));
    end

    // Randomized traffic with stalls, gaps and occasional resets.
    new_section();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < R; i++) begin
        en[i] = ($urandom_range(0, 9) != 0);
        if (q[i].size() == 0) begin
          len = $urandom_range(1, 12);
          load(i, len, W'($urandom), ($urandom_range(0, 5) != 0));
        end
      end
      full_in = ($urandom_range(0, 4) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_push_arb.md
# fifo_push_arb

Round-robin arbiter that shares the write (push) port of a FIFO between R requesters, in the write-clock domain. It grants one requester at a time for a burst of beats terminated by that requester's last flag or by a forced release at MAX_BURST beats. While the FIFO reports full it holds off pushes and never drops data. It sits directly in front of the FIFO push/push_data/full_r interface.

## Interface
- W, 32, data width in bits; must match the FIFO.
- R, 4, number of requesters; R >= 1.
- MAX_BURST, 8, maximum beats per grant; MAX_BURST >= 1.

- clk  in  1  clock (FIFO write clock).
- rst  in  1  synchronous, active-high reset.
- req  in  R  per-requester beat valid.
- req_data  in  R*W  per-requester beat data; requester i occupies bits [i*W +: W].
- req_last  in  R  marks the current beat as the final beat of requester i's burst.
- ack  out  R  one-hot; ack[i]=1 means the beat on requester i was pushed this cycle.
- fifo_full  in  1  FIFO registered full flag (full_r).
- push  out  1  FIFO push strobe.
- push_data  out  W  FIFO push data.
- grant_r  out  R  one-hot registered grant; all zeros when idle.
- busy_r  out  1  1 while in BURST.

## Operation
- State machine with states IDLE and BURST.
- Registers:
  - state.
  - grant_r.
  - rr_ptr: clog2(R) bits, or 1 bit when R==1; the index with highest priority.
  - beat_cnt: clog2(MAX_BURST)+1 bits.
- IDLE:
  - push=0, ack=0.
  - If any req is set, select the first set req scanning indices rr_ptr, rr_ptr+1, ... modulo R.
  - Set grant_r to the winner's one-hot, clear beat_cnt, and go to BURST.
  - fifo_full does not gate arbitration.
- BURST, granted index g:
  - push = req[g] & ~fifo_full.
  - push_data = req_data[g]; push_data = 0 when push=0.
  - ack[g] = push. All other ack bits are 0.
  - Requests from non-granted requesters are ignored; their ack stays 0.
- Beat accounting: every push increments beat_cnt.
- A burst ends on a pushed beat that satisfies either condition:
  - req_last[g]=1, or
  - beat_cnt == MAX_BURST-1, a forced release; the requester re-arbitrates for the rest of its data.
- On burst end:
  - Next cycle: state=IDLE, grant_r=0.
  - rr_ptr becomes (g+1) mod R.
- Stall cases. grant_r is held, nothing is pushed, and beat_cnt is unchanged when either holds:
  - req[g]=0 mid-burst.
  - fifo_full=1.
- req_last is ignored on a cycle where push=0.
- Requesters must hold req_data/req_last stable while req=1 and ack=0.
- Reset:
  - State after rst: IDLE, grant_r=0, rr_ptr=0, beat_cnt=0.
  - Outputs while rst=1 and on the cycle after: push=0, ack=0, busy_r=0, push_data=0.
  - rst mid-burst abandons the burst immediately; no push is issued in the reset cycle.

## Timing
- req rising in IDLE at cycle t: grant_r/busy_r become valid at t+1.
- The first push/ack can occur at t+1; this is combinational from req[g] and fifo_full.
- Steady-state throughput in BURST is one beat per cycle.
- There is one idle (arbitration) cycle between consecutive bursts. Sustained bandwidth with continuous requests is MAX_BURST/(MAX_BURST+1).
- Overflow safety: the FIFO asserts full_r the cycle after the filling push, and the arbiter reads fifo_full in the same cycle it would push. No push is issued while full_r=1.
- push, ack and push_data are combinational outputs. grant_r, busy_r and rr_ptr are registered.

## Test plan
- Single burst:
  - Stimulus: R=4; req[2]=1 with req_last on the 3rd beat, data 0xA0..0xA2; fifo_full=0.
  - Response: grant_r=4'b0100 at t+1; push on t+1..t+3 with data 0xA0,0xA1,0xA2; ack[2] each of those cycles; IDLE at t+4; rr_ptr=3.
- Round-robin fairness:
  - Stimulus: all four req held high, each burst 1 beat with last; run 8 grants.
  - Response: grant order 0,1,2,3,0,1,2,3; a push every other cycle.
- Forced release:
  - Stimulus: MAX_BURST=8; req[1] high with req_last=0 for 20 beats; other requesters idle.
  - Response: pushes in groups of 8 with one idle cycle between groups (8 pushes, gap, 8 pushes, gap, 4 continuing); beat data in order with no loss.
- Full stall:
  - Stimulus: fifo_full=1 for 3 cycles during the 2nd beat of a 4-beat burst.
  - Response: push=0 and ack=0 during those cycles; grant_r unchanged; beat 2 pushed on the first cycle after fifo_full falls; total of 4 pushes.
- Requester gap:
  - Stimulus: req[0] drops for 2 cycles mid-burst while req[3] is high.
  - Response: grant_r stays 4'b0001; no push for requester 3 until requester 0's last beat is pushed.
- Reset mid-burst:
  - Stimulus: rst=1 for 1 cycle during beat 2 of a burst on requester 3.
  - Response: no push that cycle; next cycle grant_r=0, busy_r=0; next arbitration starts from index 0.
